// File: rtl/crosswalk_scheduler.sv
// crosswalk_scheduler
// Shares the single pedestrian walk phase among N_REQ crosswalk buttons.
// Button rises are latched as pending requests; the OR of them is presented
// to the intersection FSM as one walk request. When the FSM opens a walk
// phase, exactly one crosswalk is granted: starved (overdue) requests first,
// lowest index among them, otherwise round-robin from a rotating pointer.
// An emergency preempt suspends any grant without losing pending requests.
//
// Ports:
//   clk            system clock, rising edge
//   Reset_n        asynchronous active-low reset
//   Req            synchronized crosswalk buttons (level), rise = new request
//   Preempt        synchronized emergency override (level)
//   oneHz_enable   one-cycle aging tick
//   Walk_Start     one-cycle pulse, FSM entered the walk phase
//   Walk_Done      one-cycle pulse, FSM left the walk phase
//   Walk_Pending   OR of all pending requests
//   Walk_Grant     one-hot crosswalk being served, zero when none
//   Pending        latched request bits
//   Overdue        some pending request has waited MAX_WAIT ticks
//   Preempt_Active high while preempted
module crosswalk_scheduler #(
  parameter int N_REQ    = 4,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic [N_REQ-1:0] Req,
  input  logic             Preempt,
  input  logic             oneHz_enable,
  input  logic             Walk_Start,
  input  logic             Walk_Done,
  output logic             Walk_Pending,
  output logic [N_REQ-1:0] Walk_Grant,
  output logic [N_REQ-1:0] Pending,
  output logic             Overdue,
  output logic             Preempt_Active
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_PREEMPT = 2'd2
  } state_t;

  state_t             state_r, state_next_s;
  logic [N_REQ-1:0]   req_q_r;
  logic [N_REQ-1:0]   pending_r, pending_next_s;
  logic [N_REQ-1:0]   grant_r, grant_next_s;
  logic [PTR_W-1:0]   ptr_r, ptr_next_s;
  logic [PTR_W-1:0]   win_idx_r, win_idx_next_s;
  logic [PTR_W-1:0]   sel_idx_s;
  logic [WAIT_W-1:0]  wait_r      [N_REQ];
  logic [WAIT_W-1:0]  wait_next_s [N_REQ];
  logic               preempt_active_r;
  logic [N_REQ-1:0]   rise_s;
  logic [N_REQ-1:0]   overdue_vec_s;
  logic               grant_done_s;

  // First set bit of vec found searching upward from start, wrapping at
  // N_REQ-1. Scanning offsets high-to-low lets the smallest offset win.
  function automatic logic [PTR_W-1:0] first_set_from(
    input logic [N_REQ-1:0] vec,
    input logic [PTR_W-1:0] start
  );
    logic [PTR_W-1:0] res;
    logic [PTR_W:0]   sum_v;
    res = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum_v = {1'b0, start} + (PTR_W + 1)'(k);
      if (sum_v >= (PTR_W + 1)'(N_REQ)) begin
        sum_v = sum_v - (PTR_W + 1)'(N_REQ);
      end
      if (vec[sum_v[PTR_W-1:0]]) begin
        res = sum_v[PTR_W-1:0];
      end
    end
    return res;
  endfunction

  assign rise_s       = Req & ~req_q_r;
  assign grant_done_s = (state_r == ST_GRANT) && Walk_Done;

  // Overdue flags per request, and winner choice for a new walk phase.
  always_comb begin
    overdue_vec_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      overdue_vec_s[i] = pending_r[i] && (wait_r[i] == MAX_WAIT_C);
    end
    if (|overdue_vec_s) begin
      sel_idx_s = first_set_from(overdue_vec_s, '0);
    end else begin
      sel_idx_s = first_set_from(pending_r, ptr_r);
    end
  end

  // Next-state logic; Preempt dominates every other event.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Preempt) begin
          state_next_s = ST_PREEMPT;
        end else if (Walk_Start && (|pending_r)) begin
          state_next_s = ST_GRANT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (Preempt) begin
          state_next_s = ST_PREEMPT;
        end else if (Walk_Done) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_GRANT;
        end
      end
      ST_PREEMPT: begin
        if (Preempt) begin
          state_next_s = ST_PREEMPT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Next values of pending bits, grant, pointer and wait counters.
  always_comb begin
    // The winner's own re-press during its grant is absorbed (grant_r is
    // zero outside GRANT); completion clears the winner after the OR.
    pending_next_s = (pending_r | (rise_s & ~grant_r))
                   & ~(grant_done_s ? grant_r : {N_REQ{1'b0}});

    if ((state_r == ST_IDLE) && (state_next_s == ST_GRANT)) begin
      grant_next_s   = N_REQ'(1) << sel_idx_s;
      win_idx_next_s = sel_idx_s;
    end else if ((state_r == ST_GRANT) && (state_next_s == ST_GRANT)) begin
      grant_next_s   = grant_r;
      win_idx_next_s = win_idx_r;
    end else begin
      grant_next_s   = '0;
      win_idx_next_s = win_idx_r;
    end

    if (grant_done_s) begin
      ptr_next_s = (win_idx_r == LAST_IDX) ? '0 : (win_idx_r + PTR_W'(1));
    end else begin
      ptr_next_s = ptr_r;
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (!pending_r[i] || (grant_done_s && grant_r[i])) begin
        wait_next_s[i] = '0;
      end else if (oneHz_enable && !grant_r[i] && (state_r != ST_PREEMPT)
                   && (wait_r[i] != MAX_WAIT_C)) begin
        wait_next_s[i] = wait_r[i] + WAIT_W'(1);
      end else begin
        wait_next_s[i] = wait_r[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered output registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_q_r          <= '0;
      pending_r        <= '0;
      grant_r          <= '0;
      ptr_r            <= '0;
      win_idx_r        <= '0;
      preempt_active_r <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        wait_r[i] <= '0;
      end
    end else begin
      req_q_r          <= Req;
      pending_r        <= pending_next_s;
      grant_r          <= grant_next_s;
      ptr_r            <= ptr_next_s;
      win_idx_r        <= win_idx_next_s;
      preempt_active_r <= (state_next_s == ST_PREEMPT);
      for (int i = 0; i < N_REQ; i++) begin
        wait_r[i] <= wait_next_s[i];
      end
    end
  end

  assign Walk_Pending   = |pending_r;
  assign Overdue        = |overdue_vec_s;
  assign Walk_Grant     = grant_r;
  assign Pending        = pending_r;
  assign Preempt_Active = preempt_active_r;

endmodule
